sdram_avmm_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port between the KyogenRV instruction-fetch master (m0) and data master (m1). Each transfer is granted round-robin, and the grant is held while the slave stalls. Outstanding pipelined reads are tracked in order so that each `readdatavalid` returns to the master that issued the read. The block sits between the core's memory ports and `new_sdram_controller_0`, in the `clk_riscv` domain.

---
 rtl/sdram_avmm_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_avmm_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avmm_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of one SDRAM slave. The command and response paths add no cycles.
// The grant is held while the slave stalls. Reads are held back while MAX_PEND reads are outstanding. Writes are never held back.
module sdram_avmm_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk_riscv,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              rsp_err
);

  localparam int PW = $clog2(MAX_PEND);
  localparam int CW = $clog2(MAX_PEND + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        state_q;
  logic          lock_own_q;
  logic          last_grant_q;
  logic          rsp_err_q;
  logic [CW-1:0] pend_cnt_q;
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic          ids_q [MAX_PEND];

  logic req0, req1, owner, own_req, own_wr, own_rd;
  logic fifo_full, fifo_empty, head, accept, push, pop;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    owner = 1'b0;
    if (state_q == ST_LOCKED) begin
      owner = lock_own_q;
    end else if (req0 && req1) begin
      owner = ~last_grant_q;
    end else begin
      owner = req1;
    end
    own_req = owner ? req1 : req0;
    // A simultaneous read+write is treated as a write.
    own_wr  = owner ? m1_write : m0_write;
    own_rd  = own_req & ~own_wr;

    fifo_full  = (pend_cnt_q == CW'(MAX_PEND));
    fifo_empty = (pend_cnt_q == '0);
    head       = ids_q[rp_q];

    s_write      = ~reset & own_req & own_wr;
    s_read       = ~reset & own_rd & ~fifo_full;
    s_address    = reset ? '0 : (owner ? m1_address : m0_address);
    s_writedata  = reset ? '0 : (owner ? m1_writedata : m0_writedata);
    s_byteenable = reset ? '0 : (owner ? m1_byteenable : m0_byteenable);

    accept         = (s_read | s_write) & ~s_waitrequest;
    m0_waitrequest = ~(accept & ~owner);
    m1_waitrequest = ~(accept & owner);

    push = s_read & ~s_waitrequest;
    pop  = ~reset & s_readdatavalid & ~fifo_empty;

    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    m0_readdatavalid = pop & ~head;
    m1_readdatavalid = pop & head;
    rsp_err          = rsp_err_q;
  end

  always_ff @(posedge clk_riscv) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lock_own_q   <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_err_q    <= 1'b0;
      pend_cnt_q   <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (own_req && !accept) begin
            state_q    <= ST_LOCKED;
            lock_own_q <= owner;
          end
        end
        default: begin
          // Falling back to IDLE on a withdrawn request keeps a misbehaving master from wedging the port.
          if (accept || !own_req) begin
            state_q <= ST_IDLE;
          end
        end
      endcase

      if (accept) begin
        last_grant_q <= owner;
      end

      if (push) begin
        ids_q[wp_q] <= owner;
        wp_q        <= wp_q + PW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   pend_cnt_q <= pend_cnt_q + CW'(1);
        2'b01:   pend_cnt_q <= pend_cnt_q - CW'(1);
        default: pend_cnt_q <= pend_cnt_q;
      endcase

      if (s_readdatavalid && fifo_empty) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_avmm_arbiter.sv
// Scoreboard bench for sdram_avmm_arbiter: directed stimulus with expected commands and responses queued for the monitors.
module tb_sdram_avmm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid, rsp_err;

  always #5 clk = ~clk;

  sdram_avmm_arbiter dut (
    .clk_riscv(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic        mst;
    logic        wr;
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic        mst;
    logic [31:0] data;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  cmd_t mon_c;
  rsp_t mon_r;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic mst, input logic wr, input logic [23:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    cmd_t c;
    c.mst = mst; c.wr = wr; c.addr = a; c.data = d; c.be = be;
    return c;
  endfunction

  function automatic rsp_t mr(input logic mst, input logic [31:0] d);
    rsp_t r;
    r.mst = mst; r.data = d;
    return r;
  endfunction

  // Command monitor: every accepted slave command must match the head of exp_cmd.
  always @(negedge clk) begin
    if ((s_read || s_write) && !s_waitrequest) begin
      chk("one_grant", 64'(m0_waitrequest ^ m1_waitrequest), 64'd1);
      if (exp_cmd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd: addr %0h accepted, none expected", s_address);
      end else begin
        mon_c = exp_cmd.pop_front();
        chk("cmd_master", 64'(m0_waitrequest), 64'(mon_c.mst));
        chk("cmd_write", 64'(s_write), 64'(mon_c.wr));
        chk("cmd_addr", 64'(s_address), 64'(mon_c.addr));
        chk("cmd_be", 64'(s_byteenable), 64'(mon_c.be));
        if (mon_c.wr) chk("cmd_data", 64'(s_writedata), 64'(mon_c.data));
      end
    end
  end

  // Response monitor: every master readdatavalid must match the head of exp_rsp.
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      chk("rsp_single", 64'(m0_readdatavalid & m1_readdatavalid), 64'd0);
      if (exp_rsp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: m0 %0b m1 %0b, none expected", m0_readdatavalid, m1_readdatavalid);
      end else begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_master", 64'(m1_readdatavalid), 64'(mon_r.mst));
        chk("rsp_data", 64'(m1_readdatavalid ? m1_readdata : m0_readdata), 64'(mon_r.data));
      end
    end
  end

  initial begin
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = 0; m1_address = 0; m0_writedata = 0; m1_writedata = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'h3;
    s_waitrequest = 0; s_readdata = 0; s_readdatavalid = 0;

    // Reset holds slave outputs quiet even with live requests.
    reset = 1; m0_read = 1; m0_address = 24'h000123; m1_write = 1; m1_address = 24'h000456;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_s_read", 64'(s_read), 64'd0);
    chk("rst_s_write", 64'(s_write), 64'd0);
    chk("rst_s_addr", 64'(s_address), 64'd0);
    chk("rst_s_wdata", 64'(s_writedata), 64'd0);
    chk("rst_m0_wait", 64'(m0_waitrequest), 64'd1);
    chk("rst_m1_wait", 64'(m1_waitrequest), 64'd1);
    chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    nxt();
    m0_read = 0; m1_write = 0;
    reset = 0;
    nxt();

    // Single read with two stall cycles, response three cycles after acceptance.
    m0_read = 1; m0_address = 24'h000100; s_waitrequest = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        s_waitrequest = 0;
        exp_cmd.push_back(mk(0, 0, 24'h000100, 0, 4'hF));
      end
      @(negedge clk);
      chk("t1_addr", 64'(s_address), 64'h100);
      chk("t1_s_read", 64'(s_read), 64'd1);
      chk("t1_m0_wait", 64'(m0_waitrequest), 64'(k != 2));
      nxt();
    end
    m0_read = 0;
    nxt(); nxt();
    s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
    exp_rsp.push_back(mr(0, 32'hDEADBEEF));
    @(negedge clk);
    chk("t1_m0_rdv", 64'(m0_readdatavalid), 64'd1);
    chk("t1_m1_rdv", 64'(m1_readdatavalid), 64'd0);
    nxt();
    s_readdatavalid = 0;

    // Round-robin from reset: both masters write continuously.
    reset = 1;
    nxt();
    reset = 0;
    m0_write = 1; m0_address = 24'h000010; m0_writedata = 32'hA0A0A0A0;
    m1_write = 1; m1_address = 24'h000020; m1_writedata = 32'hB1B1B1B1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_cmd.push_back(mk(0, 1, 24'h000010, 32'hA0A0A0A0, 4'hF));
      else            exp_cmd.push_back(mk(1, 1, 24'h000020, 32'hB1B1B1B1, 4'h3));
      @(negedge clk);
      nxt();
    end
    m0_write = 0; m1_write = 0;
    nxt();

    // Lock: m1 stalls five cycles while m0 also requests.
    m1_write = 1; m1_address = 24'h000200; m1_writedata = 32'h22222222; s_waitrequest = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        m0_write = 1; m0_address = 24'h000300; m0_writedata = 32'h33333333;
      end
      @(negedge clk);
      chk("lock_addr", 64'(s_address), 64'h200);
      chk("lock_m0_wait", 64'(m0_waitrequest), 64'd1);
      nxt();
    end
    s_waitrequest = 0;
    exp_cmd.push_back(mk(1, 1, 24'h000200, 32'h22222222, 4'h3));
    @(negedge clk);
    nxt();
    m1_write = 0;
    exp_cmd.push_back(mk(0, 1, 24'h000300, 32'h33333333, 4'hF));
    @(negedge clk);
    nxt();
    m0_write = 0;

    // Full FIFO: four reads accepted, fifth held until a pop has been registered.
    m0_read = 1;
    for (int k = 0; k < 4; k++) begin
      m0_address = 24'h000400 + 24'(4 * k);
      exp_cmd.push_back(mk(0, 0, m0_address, 0, 4'hF));
      @(negedge clk);
      nxt();
    end
    m0_address = 24'h000410;
    @(negedge clk);
    chk("full_s_read", 64'(s_read), 64'd0);
    chk("full_m0_wait", 64'(m0_waitrequest), 64'd1);
    nxt();
    s_readdatavalid = 1; s_readdata = 32'h00001111;
    exp_rsp.push_back(mr(0, 32'h00001111));
    @(negedge clk);
    chk("full_pop_s_read", 64'(s_read), 64'd0);
    nxt();
    s_readdatavalid = 0;
    exp_cmd.push_back(mk(0, 0, 24'h000410, 0, 4'hF));
    @(negedge clk);
    chk("full_m0_wait_after", 64'(m0_waitrequest), 64'd0);
    nxt();
    m0_read = 0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1; s_readdata = 32'h00002220 + 32'(k);
      exp_rsp.push_back(mr(0, s_readdata));
      @(negedge clk);
      nxt();
    end
    s_readdatavalid = 0;

    // Ordering: m0, m1, m0 reads; responses route back in issue order.
    for (int k = 0; k < 3; k++) begin
      m0_read = (k != 1); m1_read = (k == 1);
      m0_address = 24'h000500 + 24'(4 * k); m1_address = m0_address;
      exp_cmd.push_back(mk(k == 1, 0, m0_address, 0, (k == 1) ? 4'h3 : 4'hF));
      @(negedge clk);
      nxt();
    end
    m0_read = 0; m1_read = 0;
    for (int k = 0; k < 3; k++) begin
      s_readdatavalid = 1; s_readdata = 32'hAAAA0000 + 32'(k);
      exp_rsp.push_back(mr(k == 1, s_readdata));
      @(negedge clk);
      nxt();
    end
    s_readdatavalid = 0;

    // Reset mid-operation: pending IDs discarded, stray response flagged.
    @(negedge clk);
    chk("pre_err", 64'(rsp_err), 64'd0);
    nxt();
    for (int k = 0; k < 3; k++) begin
      m0_read = (k != 1); m1_read = (k == 1);
      m0_address = 24'h000600 + 24'(4 * k); m1_address = m0_address;
      exp_cmd.push_back(mk(k == 1, 0, m0_address, 0, (k == 1) ? 4'h3 : 4'hF));
      @(negedge clk);
      nxt();
    end
    m0_read = 0; m1_read = 0;
    reset = 1;
    nxt();
    reset = 0;
    s_readdatavalid = 1; s_readdata = 32'h00000BAD;
    @(negedge clk);
    chk("stray_m0_rdv", 64'(m0_readdatavalid), 64'd0);
    chk("stray_m1_rdv", 64'(m1_readdatavalid), 64'd0);
    chk("stray_err_same_cycle", 64'(rsp_err), 64'd0);
    nxt();
    s_readdatavalid = 0;
    @(negedge clk);
    chk("stray_err", 64'(rsp_err), 64'd1);
    chk("stray_pend_cnt", 64'(dut.pend_cnt_q), 64'd0);
    nxt(); nxt();
    @(negedge clk);
    chk("err_sticky", 64'(rsp_err), 64'd1);
    nxt();

    chk("sb_cmd_drained", 64'(exp_cmd.size()), 64'd0);
    chk("sb_rsp_drained", 64'(exp_rsp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
